// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pkg
//  Purpose  : Shared constants, state encoding and helpers for the
//             multiply-accumulate sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Operand width; one MULT cycle per multiplier bit
    localparam int OP_WIDTH   = 8;
    localparam int BIT_CNT_W  = 3;
    localparam int TERM_CNT_W = 4;

    // Value of bit_cnt during the final MULT cycle of a term
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(OP_WIDTH - 1);

    // Product mux selects (datapath 3-to-1 mux s input)
    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_ADDSH = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;

    // Controller state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_INIT = 3'd1;
    localparam state_t ST_LOAD = 3'd2;
    localparam state_t ST_MULT = 3'd3;
    localparam state_t ST_ACC  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Shift-and-add step: add the multiplicand only when the multiplier LSB is set
    function automatic logic [1:0] mult_sel(input logic b);
        return b ? SEL_ADDSH : SEL_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mac_counter
//  Purpose  : Parameterised up-counter with synchronous clear and enable.
//             Clear has priority over enable.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count register: async reset, then clear, then increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mac_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mac_controller
//  Purpose  : Sequencer for a shift-and-add multiply-accumulate datapath.
//             Clears the accumulator, then for each of n_terms products
//             fetches an operand pair, runs OP_WIDTH shift/add steps and
//             adds the product into the accumulator, finally pulsing done.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_controller
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] n_terms,
    input  logic       op_valid,
    input  logic       b_lsb,
    output logic       ready,
    output logic       op_req,
    output logic       ld_ops,
    output logic       p_en,
    output logic [1:0] sel_p,
    output logic       acc_en,
    output logic       acc_clr,
    output logic       done
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [TERM_CNT_W-1:0]   r_n_terms;
    logic                    w_latch_n;

    logic [BIT_CNT_W-1:0]    w_bit_cnt;
    logic                    w_bit_clr;
    logic                    w_bit_en;
    logic [TERM_CNT_W-1:0]   w_term_cnt;
    logic                    w_term_clr;
    logic                    w_term_en;

    // Counts multiplier bits within one product
    mac_counter #(
        .WIDTH (BIT_CNT_W)
    ) u_bit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_bit_clr),
        .i_en    (w_bit_en),
        .o_count (w_bit_cnt)
    );

    // Counts products accumulated in the current job
    mac_counter #(
        .WIDTH (TERM_CNT_W)
    ) u_term_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_term_clr),
        .i_en    (w_term_en),
        .o_count (w_term_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job length captured at start so later n_terms changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_terms <= '0;
        end else if (w_latch_n) begin
            r_n_terms <= n_terms;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        w_latch_n    = 1'b0;
        w_bit_clr    = 1'b0;
        w_bit_en     = 1'b0;
        w_term_clr   = 1'b0;
        w_term_en    = 1'b0;
        ready        = 1'b0;
        op_req       = 1'b0;
        ld_ops       = 1'b0;
        p_en         = 1'b0;
        sel_p        = SEL_ZERO;
        acc_en       = 1'b0;
        acc_clr      = 1'b0;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_latch_n    = 1'b1;
                    w_term_clr   = 1'b1;
                    w_state_next = ST_INIT;
                end
            end

            ST_INIT: begin
                acc_clr      = 1'b1;
                w_state_next = (r_n_terms == '0) ? ST_DONE : ST_LOAD;
            end

            ST_LOAD: begin
                op_req = 1'b1;
                if (op_valid) begin
                    ld_ops       = 1'b1;
                    p_en         = 1'b1;
                    sel_p        = SEL_ZERO;
                    w_bit_clr    = 1'b1;
                    w_state_next = ST_MULT;
                end
            end

            ST_MULT: begin
                p_en  = 1'b1;
                sel_p = mult_sel(b_lsb);
                // Hold the counter on the last bit so it never wraps
                if (w_bit_cnt == BIT_LAST) begin
                    w_state_next = ST_ACC;
                end else begin
                    w_bit_en = 1'b1;
                end
            end

            ST_ACC: begin
                acc_en    = 1'b1;
                w_term_en = 1'b1;
                if ((w_term_cnt + TERM_CNT_W'(1)) == r_n_terms) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end

            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
